// File: rtl/hybridsub8_pipe.sv
// 8-bit two-stage pipelined subtractor, D = X - Y - Bin, formed as X + ~Y + ~Bin.
// Carry lookahead covers the low bits in stage 1; the top bits ripple in stage 2.
module hybridsub8_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned LA_BITS = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Xi,
    input  logic [WIDTH-1:0] Yi,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Di,
    output logic             Bout,
    output logic             V,
    output logic             Z
);

    // Handshake control
    logic out_free;
    logic in_xfer;
    logic s2_load;

    // Stage 1 combinational terms
    logic [WIDTH-1:0] yn;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [LA_BITS:0] c;

    // Stage 1 registers
    logic [WIDTH-1:0]       s1_p_q, s1_p_d;
    logic [WIDTH-1:LA_BITS] s1_g_q, s1_g_d;
    logic [LA_BITS:0]       s1_c_q, s1_c_d;
    logic                   s1_valid_q, s1_valid_d;

    // Stage 2 combinational terms
    logic             c7;
    logic             c8;
    logic [WIDTH-1:0] di_calc;

    // Stage 2 (output) registers
    logic [WIDTH-1:0] di_q, di_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             out_valid_q, out_valid_d;

    assign out_free = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | out_free;
    assign in_xfer  = in_valid & in_ready;
    assign s2_load  = s1_valid_q & out_free;

    always_comb begin
        yn   = ~Yi;
        p    = Xi ^ yn;
        g    = Xi & yn;
        c    = '0;
        c[0] = ~Bin;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
             | (p[4] & p[3] & p[2] & g[1])
             | (p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
        c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & g[3])
             | (p[5] & p[4] & p[3] & g[2])
             | (p[5] & p[4] & p[3] & p[2] & g[1])
             | (p[5] & p[4] & p[3] & p[2] & p[1] & g[0])
             | (p[5] & p[4] & p[3] & p[2] & p[1] & p[0] & c[0]);
    end

    always_comb begin
        s1_p_d     = s1_p_q;
        s1_g_d     = s1_g_q;
        s1_c_d     = s1_c_q;
        s1_valid_d = s1_valid_q;
        if (in_xfer) begin
            s1_p_d     = p;
            s1_g_d     = g[WIDTH-1:LA_BITS];
            s1_c_d     = c;
            s1_valid_d = 1'b1;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // Ripple through the two bits above the lookahead block
    always_comb begin
        c7      = s1_g_q[6] | (s1_p_q[6] & s1_c_q[6]);
        c8      = s1_g_q[7] | (s1_p_q[7] & c7);
        di_calc = s1_p_q ^ {c7, s1_c_q};
    end

    always_comb begin
        di_d        = di_q;
        bout_d      = bout_q;
        v_d         = v_q;
        z_d         = z_q;
        out_valid_d = out_valid_q;
        if (s2_load) begin
            di_d        = di_calc;
            bout_d      = ~c8;
            v_d         = c8 ^ c7;
            z_d         = (di_calc == '0);
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_p_q      <= '0;
            s1_g_q      <= '0;
            s1_c_q      <= '0;
            s1_valid_q  <= 1'b0;
            di_q        <= '0;
            bout_q      <= 1'b0;
            v_q         <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_p_q      <= s1_p_d;
            s1_g_q      <= s1_g_d;
            s1_c_q      <= s1_c_d;
            s1_valid_q  <= s1_valid_d;
            di_q        <= di_d;
            bout_q      <= bout_d;
            v_q         <= v_d;
            z_q         <= z_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Di        = di_q;
    assign Bout      = bout_q;
    assign V         = v_q;
    assign Z         = z_q;

endmodule

// File: tb/tb_hybridsub8_pipe.sv
// Directed and randomized checks of hybridsub8_pipe: arithmetic, flags, latency,
// backpressure, mid-flight reset, and ordering against a 9-bit reference model.
module tb_hybridsub8_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] Xi;
    logic [7:0] Yi;
    logic       Bin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Di;
    logic       Bout;
    logic       V;
    logic       Z;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];
    int          n_in  = 0;
    int          n_out = 0;

    hybridsub8_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Xi       (Xi),
        .Yi       (Yi),
        .Bin      (Bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Di       (Di),
        .Bout     (Bout),
        .V        (V),
        .Z        (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result packed as {Di, Bout, V, Z}
    function automatic logic [10:0] model(input logic [7:0] x, input logic [7:0] y,
                                          input logic b);
        logic [8:0] diff;
        logic       ovf;
        diff = {1'b0, x} - {1'b0, y} - {8'd0, b};
        ovf  = (x[7] != y[7]) && (diff[7] != x[7]);
        return {diff[7:0], diff[8], ovf, (diff[7:0] == 8'd0)};
    endfunction

    // Checks {out_valid, Di, Bout, V, Z} as one packed word
    task automatic chk_res(input string tag, input logic [7:0] d, input logic b,
                           input logic v, input logic z);
        chk(tag, {20'd0, out_valid, Di, Bout, V, Z}, {20'd0, 1'b1, d, b, v, z});
    endtask

    // One operand set with out_ready=1; result must appear exactly two edges later
    task automatic send_one(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic b, input logic [7:0] d, input logic bo,
                            input logic v, input logic z);
        Xi       = x;
        Yi       = y;
        Bin      = b;
        in_valid = 1'b1;
        #1;
        chk({tag, "_inrdy"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        tick();
        chk_res(tag, d, bo, v, z);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Xi        = 8'h00;
        Yi        = 8'h00;
        Bin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_outs", {20'd0, out_valid, Di, Bout, V, Z}, 32'd0);
        chk("rst_inrdy", {31'd0, in_ready}, 32'd1);

        send_one("p50m20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        send_one("p20m50", 8'h20, 8'h50, 1'b0, 8'hD0, 1'b1, 1'b0, 1'b0);
        send_one("p80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        send_one("p00m00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        send_one("p33m33", 8'h33, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        send_one("p40m3Fb", 8'h40, 8'h3F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        send_one("p7FmFF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
        send_one("pFFmFFb", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick();
        chk("drop_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepted, third stalls, then drain in order
        out_ready = 1'b0;
        Xi = 8'h10; Yi = 8'h01; Bin = 1'b0; in_valid = 1'b1;
        tick();
        Xi = 8'h20; Yi = 8'h02;
        #1;
        chk("bp_inrdy2", {31'd0, in_ready}, 32'd1);
        tick();
        Xi = 8'h30; Yi = 8'h03;
        #1;
        chk("bp_stall_inrdy", {31'd0, in_ready}, 32'd0);
        chk_res("bp_hold0", 8'h0F, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_stall_inrdy2", {31'd0, in_ready}, 32'd0);
        chk_res("bp_hold1", 8'h0F, 1'b0, 1'b0, 1'b0);
        tick();
        chk_res("bp_hold2", 8'h0F, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp_release_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk_res("bp_res1", 8'h1E, 1'b0, 1'b0, 1'b0);
        tick();
        chk_res("bp_res2", 8'h2D, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Reset one edge after acceptance discards the in-flight operands
        Xi = 8'h55; Yi = 8'h11; Bin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_outs", {20'd0, out_valid, Di, Bout, V, Z}, 32'd0);
        chk("mrst_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("mrst_no44", {31'd0, out_valid}, 32'd0);
        send_one("post_rst", 8'h9A, 8'h0B, 1'b1, 8'h8E, 1'b0, 1'b0, 1'b0);
        tick();

        // Random sweep with random valid/ready toggling
        for (int i = 0; i < 400; i++) begin
            Xi        = 8'($urandom);
            Yi        = 8'($urandom);
            Bin       = 1'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("rnd_extra", {20'd0, out_valid, Di, Bout, V, Z}, 32'd0);
                end else begin
                    chk("rnd_res", {21'd0, Di, Bout, V, Z}, {21'd0, exp_q.pop_front()[10:0]});
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                exp_q.push_back({1'b0, model(Xi, Yi, Bin)});
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("drain_extra", {20'd0, out_valid, Di, Bout, V, Z}, 32'd0);
                end else begin
                    chk("drain_res", {21'd0, Di, Bout, V, Z}, {21'd0, exp_q.pop_front()[10:0]});
                end
            end
            tick();
        end
        chk("rnd_count", 32'(n_out), 32'(n_in));
        chk("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
